// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC, req/ack imem port, IF/ID register
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetch/perf_stall/perf_flush counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cu_wpcir,
  input  logic              cu_branch,
  input  logic [31:0]       branch_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc4,
  output logic              id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_fetch,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush
`endif
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] id_instr_nxt, id_pc4_nxt;
  logic        id_valid_nxt;
  logic        first_cyc;
  logic        ack_eff;
  logic [31:0] pc_plus4;

  if (CNT_W < 1) begin : g_bad_cnt_w
  end

  // An ack in the first cycle after reset may belong to an abandoned access.
  assign ack_eff  = imem_ack & ~first_cyc;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if_valid  = 1'b0;
    if_instr  = 32'h0;
    case (state)
      S_REQ: begin
        imem_req = rst_n;
        if_valid = ack_eff;
        if_instr = ack_eff ? imem_rdata : 32'h0;
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if_instr = hold_buf;
      end
      S_DROP: begin
        imem_req  = rst_n;
        imem_addr = drop_addr;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    hold_buf_nxt  = hold_buf;
    id_instr_nxt  = 32'h0;
    id_pc4_nxt    = id_pc4;
    id_valid_nxt  = 1'b0;
    if (cu_branch) begin
      pc_nxt = branch_target & ~32'd3;
      // An outstanding access must still complete at its original address.
      if (state != S_HOLD && !ack_eff) begin
        state_nxt = S_DROP;
        if (state == S_REQ) drop_addr_nxt = pc;
      end else begin
        state_nxt = S_REQ;
      end
    end else if (cu_wpcir && if_valid) begin
      if (state == S_REQ) begin
        hold_buf_nxt = imem_rdata;
        state_nxt    = S_HOLD;
      end
    end else if (if_valid) begin
      id_instr_nxt = if_instr;
      id_pc4_nxt   = pc_plus4;
      id_valid_nxt = 1'b1;
      pc_nxt       = pc_plus4;
      state_nxt    = S_REQ;
    end else if (state == S_DROP && ack_eff) begin
      state_nxt = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      hold_buf  <= 32'h0;
      id_instr  <= 32'h0;
      id_pc4    <= 32'h0;
      id_valid  <= 1'b0;
      first_cyc <= 1'b1;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      hold_buf  <= hold_buf_nxt;
      id_instr  <= id_instr_nxt;
      id_pc4    <= id_pc4_nxt;
      id_valid  <= id_valid_nxt;
      first_cyc <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (id_valid_nxt)         perf_fetch <= perf_fetch + CNT_W'(1);
      if (cu_wpcir && if_valid) perf_stall <= perf_stall + CNT_W'(1);
      if (cu_branch)            perf_flush <= perf_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cu_wpcir = 1'b0;
  logic        cu_branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, imem_ack, if_valid, id_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, id_instr, id_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  bit          rnd_wait = 1'b0;
  int          wcnt, cur_wait;

  if_fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cu_wpcir(cu_wpcir), .cu_branch(cu_branch),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_instr(if_instr),
    .if_valid(if_valid), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: acks once the request has been held cur_wait cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= 0;
      cur_wait <= wait_n;
    end else if (imem_ack) begin
      wcnt     <= 0;
      cur_wait <= rnd_wait ? int'($urandom_range(0, 2)) : wait_n;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end
  end
  assign imem_ack   = imem_req && (wcnt >= cur_wait);
  assign imem_rdata = imem_ack ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] word(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w, input bit r);
    rst_n     = 1'b0;
    cu_wpcir  = 1'b0;
    cu_branch = 1'b0;
    wait_n    = w;
    rnd_wait  = r;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wp, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifi;
    logic        idv;
    logic [31:0] idi, pc4;
  } vec_t;

  vec_t tbl [15];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc, prev_addr;
    bit          found, seen, prev_pend, ifv, br, st, exp_v;
    int          delivered;

    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
    mem[17] = 32'h8C22_0000;

    //        wp br tgt            req addr           ifv ifi            idv idi            pc4
    tbl[0]  = '{0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0};
    tbl[1]  = '{0, 0, 32'h0,        1, 32'h0,        1, 32'h1,        1, 32'h1,        32'h4};
    tbl[2]  = '{0, 0, 32'h0,        1, 32'h4,        1, 32'h2,        1, 32'h2,        32'h8};
    tbl[3]  = '{0, 0, 32'h0,        1, 32'h8,        1, 32'h3,        1, 32'h3,        32'hC};
    tbl[4]  = '{0, 0, 32'h0,        1, 32'hC,        1, 32'h4,        1, 32'h4,        32'h10};
    tbl[5]  = '{0, 1, 32'h43,       1, 32'h10,       1, 32'h5,        0, 32'h0,        32'h0};
    tbl[6]  = '{0, 0, 32'h0,        1, 32'h40,       1, 32'h11,       1, 32'h11,       32'h44};
    tbl[7]  = '{1, 0, 32'h0,        1, 32'h44,       1, 32'h8C220000, 0, 32'h0,        32'h0};
    tbl[8]  = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h8C220000, 1, 32'h8C220000, 32'h48};
    tbl[9]  = '{1, 0, 32'h0,        1, 32'h48,       1, 32'h13,       0, 32'h0,        32'h0};
    tbl[10] = '{1, 0, 32'h0,        0, 32'h0,        1, 32'h13,       0, 32'h0,        32'h0};
    tbl[11] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       1, 32'h13,       32'h4C};
    tbl[12] = '{0, 1, 32'hFFFFFFFF, 1, 32'h4C,       1, 32'h14,       0, 32'h0,        32'h0};
    tbl[13] = '{0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'h100,      1, 32'h100,      32'h0};
    tbl[14] = '{0, 0, 32'h0,        1, 32'h0,        1, 32'h1,        1, 32'h1,        32'h4};

    #1;
    check("reset imem_req", imem_req, 0);
    check("reset if_valid", if_valid, 0);
    check("reset id_valid", id_valid, 0);
    check("reset id_instr", id_instr, 0);
    check("reset id_pc4", id_pc4, 0);

    // Table: 0-wait memory, sequential fetch, branch, load-use stalls, PC wrap.
    do_reset(0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cu_wpcir = tbl[i].wp;
      cu_branch = tbl[i].br;
      branch_target = tbl[i].tgt;
      #1;
      check($sformatf("row%0d imem_req", i), imem_req, tbl[i].req);
      if (tbl[i].req) check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("row%0d if_valid", i), if_valid, tbl[i].ifv);
      check($sformatf("row%0d if_instr", i), if_instr, tbl[i].ifi);
      tick();
      check($sformatf("row%0d id_valid", i), id_valid, tbl[i].idv);
      check($sformatf("row%0d id_instr", i), id_instr, tbl[i].idi);
      if (tbl[i].idv) check($sformatf("row%0d id_pc4", i), id_pc4, tbl[i].pc4);
    end
    cu_wpcir = 1'b0;
    cu_branch = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, 9);
    check("perf_stall", perf_stall, 3);
    check("perf_flush", perf_flush, 2);
`endif

    // 2-wait memory: branch during a fetch of 0x20, the word must be discarded.
    do_reset(2, 1'b0);
    cu_branch = 1'b1;
    branch_target = 32'h20;
    tick();
    cu_branch = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (imem_req && imem_addr == 32'h20) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("s4 reach 0x20", found, 1);
    check("s4 first cycle ack", imem_ack, 0);
    cu_branch = 1'b1;
    branch_target = 32'h80;
    tick();
    cu_branch = 1'b0;
    check("s4 bubble", id_valid, 0);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      check("s4 addr held", imem_addr, 32'h20);
      check("s4 if_valid dropped", if_valid, 0);
      if (imem_ack) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    check("s4 ack seen", seen, 1);
    check("s4 req after drop", imem_req, 1);
    check("s4 addr after drop", imem_addr, 32'h80);
    for (int n = 0; n < 20 && !id_valid; n++) tick();
    check("s4 id_valid", id_valid, 1);
    check("s4 id_instr", id_instr, 32'h21);
    check("s4 id_pc4", id_pc4, 32'h84);

    // Reset mid-fetch at pc 0x100 with a valid instruction in ID.
    do_reset(1, 1'b0);
    cu_branch = 1'b1;
    branch_target = 32'hF8;
    tick();
    cu_branch = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (imem_req && imem_addr == 32'h100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("s6 reach 0x100", found, 1);
    check("s6 id_valid before reset", id_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6 imem_req in reset", imem_req, 0);
    check("s6 id_valid in reset", id_valid, 0);
    check("s6 id_instr in reset", id_instr, 0);
    check("s6 if_valid in reset", if_valid, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("s6 req after release", imem_req, 1);
    check("s6 addr after release", imem_addr, 32'h0);

    // Random stalls, branches and wait states against a program-order model.
    do_reset(0, 1'b1);
    exp_pc = 32'h0;
    delivered = 0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      cu_wpcir = ($urandom_range(0, 3) == 0);
      cu_branch = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      #1;
      if (prev_pend) begin
        check("rnd req held", imem_req, 1);
        check("rnd addr stable", imem_addr, prev_addr);
      end
      ifv = if_valid;
      check("rnd if_instr", if_instr, ifv ? word(exp_pc) : 32'h0);
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      br = cu_branch;
      st = cu_wpcir;
      tick();
      exp_v = !br && !st && ifv;
      check("rnd id_valid", id_valid, exp_v);
      if (exp_v) begin
        check("rnd id_instr", id_instr, word(exp_pc));
        check("rnd id_pc4", id_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        check("rnd bubble instr", id_instr, 32'h0);
      end
      if (br) exp_pc = branch_target & ~32'd3;
    end
    cu_wpcir = 1'b0;
    cu_branch = 1'b0;
    check("rnd progress", delivered >= 300, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
